// File: rtl/css_tb_svc_pkg.sv
// rtl/css_tb_svc_pkg.sv - shared types and constants for the bench service sequencer
package css_tb_svc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } svc_state_e;

    typedef enum logic {
        SVC_PULSE  = 1'b0,
        SVC_TOGGLE = 1'b1
    } svc_mode_e;

    // Substituted for a zero hold so every service lasts at least one cycle.
    localparam int SVC_DEF_HOLD = 1;

endpackage

// File: rtl/css_tb_svc_rr_arb.sv
// rtl/css_tb_svc_rr_arb.sv - combinational round-robin pick starting after last_grant
module css_tb_svc_rr_arb #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   last_grant,
    output logic              grant_valid,
    output logic [CH_W-1:0]   grant_idx
);

    // Walk offsets from farthest to nearest so the nearest pending channel wins.
    always_comb begin
        int j;
        grant_valid = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int off = NUM_CH; off >= 1; off--) begin
            j = (int'(last_grant) + off) % NUM_CH;
            if (pending[j]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(j);
            end
        end
    end

endmodule

// File: rtl/css_tb_svc_sequencer.sv
// rtl/css_tb_svc_sequencer.sv - round-robin service sequencer driving pulse/toggle action lines
module css_tb_svc_sequencer
    import css_tb_svc_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int HOLD_W = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        mode_i,
    input  logic [NUM_CH*HOLD_W-1:0] hold_i,
    output logic [NUM_CH-1:0]        action_o,
    output logic [NUM_CH-1:0]        done_o,
    output logic                     busy_o,
    output logic [CH_W-1:0]          active_ch_o,
    output logic                     proto_err_o
);

    svc_state_e        state;
    svc_mode_e         mode_r;
    logic [HOLD_W-1:0] cnt;
    logic              withdrawn;
    logic [CH_W-1:0]   last_grant;

    logic [NUM_CH-1:0] pending;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_idx;
    logic [HOLD_W-1:0] grant_hold;

    assign pending    = req_i & ~done_o;
    assign grant_hold = hold_i[int'(grant_idx)*HOLD_W +: HOLD_W];

    css_tb_svc_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .pending     (pending),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode_r      <= SVC_PULSE;
            cnt         <= '0;
            withdrawn   <= 1'b0;
            last_grant  <= CH_W'(NUM_CH - 1);
            action_o    <= '0;
            done_o      <= '0;
            busy_o      <= 1'b0;
            active_ch_o <= '0;
            proto_err_o <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (!req_i[n]) done_o[n] <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state       <= ACTIVE;
                        busy_o      <= 1'b1;
                        active_ch_o <= grant_idx;
                        last_grant  <= grant_idx;
                        withdrawn   <= 1'b0;
                        mode_r      <= svc_mode_e'(mode_i[grant_idx]);
                        cnt         <= (grant_hold == '0) ? HOLD_W'(SVC_DEF_HOLD) : grant_hold;
                        if (mode_i[grant_idx]) action_o[grant_idx] <= ~action_o[grant_idx];
                        else                   action_o[grant_idx] <= 1'b1;
                    end
                end

                ACTIVE: begin
                    cnt <= cnt - HOLD_W'(1);
                    if (!req_i[active_ch_o]) begin
                        withdrawn   <= 1'b1;
                        proto_err_o <= 1'b1;
                    end
                    if (cnt == HOLD_W'(1)) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        active_ch_o <= '0;
                        // A withdrawn request still runs out its hold but never completes.
                        if (!withdrawn && req_i[active_ch_o]) done_o[active_ch_o] <= 1'b1;
                        if (mode_r == SVC_PULSE) action_o[active_ch_o] <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_css_tb_svc_sequencer.sv
// tb/tb_css_tb_svc_sequencer.sv - self-checking bench for css_tb_svc_sequencer
module tb_css_tb_svc_sequencer;

    localparam int N  = 8;
    localparam int HW = 8;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    mode = '0;
    logic [N*HW-1:0] hold = '0;
    logic [N-1:0]    action;
    logic [N-1:0]    done;
    logic            busy;
    logic [CW-1:0]   active_ch;
    logic            proto_err;

    css_tb_svc_sequencer #(.NUM_CH(N), .HOLD_W(HW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .mode_i      (mode),
        .hold_i      (hold),
        .action_o    (action),
        .done_o      (done),
        .busy_o      (busy),
        .active_ch_o (active_ch),
        .proto_err_o (proto_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a service is an interval [grant, grant+H] in absolute edge count.
    int           cyc;
    int           m_ch;
    int           m_end;
    bit           m_pulse;
    bit           m_bad;
    int           m_last;
    logic [N-1:0] m_act;
    logic [N-1:0] m_done;
    bit           m_err;

    task automatic model_reset();
        cyc = 0; m_ch = -1; m_end = 0; m_pulse = 0; m_bad = 0;
        m_last = N - 1; m_act = '0; m_done = '0; m_err = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] nd;
        logic [N-1:0] pend;
        int g, h;
        cyc++;
        nd = m_done & req;
        if (m_ch >= 0) begin
            if (!req[m_ch]) begin m_bad = 1; m_err = 1; end
            if (cyc == m_end) begin
                if (!m_bad) nd[m_ch] = 1'b1;
                if (m_pulse) m_act[m_ch] = 1'b0;
                m_ch = -1;
            end
        end else begin
            pend = req & ~m_done;
            g = -1;
            for (int k = 1; k <= N && g < 0; k++)
                if (pend[(m_last + k) % N]) g = (m_last + k) % N;
            if (g >= 0) begin
                h = int'(hold[g*HW +: HW]);
                if (h == 0) h = 1;
                m_end   = cyc + h;
                m_pulse = !mode[g];
                m_act[g] = m_pulse ? 1'b1 : ~m_act[g];
                m_bad   = 0;
                m_last  = g;
                m_ch    = g;
            end
        end
        m_done = nd;
    endtask

    task automatic compare_all();
        chk("action", action, m_act);
        chk("done", done, m_done);
        chk("busy", busy, m_ch >= 0);
        chk("active_ch", active_ch, (m_ch >= 0) ? m_ch : 0);
        chk("proto_err", proto_err, m_err);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_hold(input int ch, input int val);
        hold[ch*HW +: HW] = HW'(val);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_action", action, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_active", active_ch, 0);
        chk("rst_err", proto_err, 0);
        model_reset();
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic agent();
        for (int n = 0; n < N; n++) begin
            if (!req[n]) begin
                if (!m_done[n] && $urandom_range(3) == 0) req[n] = 1'b1;
            end else if (m_done[n]) begin
                if ($urandom_range(1) == 1) req[n] = 1'b0;
            end else if ($urandom_range(150) == 0) begin
                req[n] = 1'b0;
            end
            set_hold(n, $urandom_range(6));
        end
        mode = N'($urandom);
    endtask

    int cnt_hi;

    initial begin
        model_reset();
        #10;
        do_reset();

        // All channels request after reset: channel 0 first.
        req = '1; mode = '0; hold = {N{8'd1}};
        step();
        chk("first_grant", active_ch, 0);
        step();
        do_reset();

        // Single PULSE on ch2, hold 5.
        mode = '0; hold = {N{8'd1}};
        set_hold(2, 5); req[2] = 1'b1;
        cnt_hi = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (action[2]) cnt_hi++;
        end
        chk("pulse_len", cnt_hi, 5);
        chk("pulse_done", done[2], 1);
        req[2] = 1'b0;
        step();
        chk("pulse_done_clr", done[2], 0);

        // Round robin after ch3: ch5 before ch0.
        set_hold(3, 1); req[3] = 1'b1;
        steps(2);
        req[3] = 1'b0;
        step();
        set_hold(0, 1); set_hold(5, 1);
        req[0] = 1'b1; req[5] = 1'b1;
        step();
        chk("rr_first", active_ch, 5);
        steps(2);
        chk("rr_second", active_ch, 0);
        req = '0;
        steps(3);

        // From reset, ch0/3/7 in order.
        do_reset();
        req[0] = 1'b1; req[3] = 1'b1; req[7] = 1'b1;
        step(); chk("order_0", active_ch, 0);
        steps(2); chk("order_3", active_ch, 3);
        steps(2); chk("order_7", active_ch, 7);
        req = '0;
        steps(3);

        // Two TOGGLE services on ch1, hold 3.
        do_reset();
        mode[1] = 1'b1; set_hold(1, 3); req[1] = 1'b1;
        step();
        chk("tog_on", action[1], 1);
        steps(3);
        chk("tog_busy_end", busy, 0);
        chk("tog_hold", action[1], 1);
        req[1] = 1'b0;
        step();
        req[1] = 1'b1;
        step();
        chk("tog_off", action[1], 0);
        steps(3);
        req = '0; mode = '0;
        step();

        // PULSE with hold 0 behaves as hold 1.
        set_hold(3, 0); req[3] = 1'b1;
        step();
        chk("h0_on", action[3], 1);
        step();
        chk("h0_off", action[3], 0);
        req = '0;
        step();

        // Protocol error: ch4 hold 10, request dropped early.
        set_hold(4, 10); req[4] = 1'b1;
        cnt_hi = 0;
        step(); if (action[4]) cnt_hi++;
        for (int i = 0; i < 3; i++) begin step(); if (action[4]) cnt_hi++; end
        req[4] = 1'b0;
        for (int i = 0; i < 8; i++) begin step(); if (action[4]) cnt_hi++; end
        chk("err_len", cnt_hi, 10);
        chk("err_nodone", done[4], 0);
        chk("err_flag", proto_err, 1);
        steps(3);
        chk("err_sticky", proto_err, 1);

        // Reset mid TOGGLE service on ch6, then normal re-request.
        do_reset();
        mode[6] = 1'b1; set_hold(6, 5); req[6] = 1'b1;
        step();
        chk("mid_on", action[6], 1);
        step();
        do_reset();
        mode[6] = 1'b1; set_hold(6, 2); req[6] = 1'b1;
        step();
        chk("re_busy", busy, 1);
        chk("re_ch", active_ch, 6);
        steps(2);
        chk("re_done", done[6], 1);
        req = '0;
        step();

        // Random phase with periodic asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c % 700 == 699) do_reset();
            else agent();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
